// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner: walks the select lines of a downstream 4-to-1 mux through
// the enabled channels. Each select is held for DWELL cycles plus one sample
// cycle, and the mux output is captured into a 4-bit snapshot word.
// Optional feature macro: MUX_SCAN_CONT_EN. When it is defined and start is
// held high, the scanner restarts after each completed scan.
module mux_sel_scanner #(
  parameter int DWELL = 2,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       mux_out,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       done,
  output logic [3:0] sample,
  output logic       sample_valid
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DWELL,
    ST_SAMPLE,
    ST_FINISH
  } state_t;

  localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       sample_q, sample_d;
  logic             valid_q, valid_d;

  // Lowest enabled channel whose index is at least lo.
  // Result is {found, index}; found=0 means no such channel.
  function automatic logic [2:0] pickAbove(input logic [3:0] m, input logic [2:0] lo);
    logic [2:0] r;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      if (m[k] && (k >= int'(lo))) begin
        r = {1'b1, 2'(k)};
      end
    end
    return r;
  endfunction

  logic [2:0] firstPick;
  logic [2:0] nextPick;
`ifdef MUX_SCAN_CONT_EN
  logic [2:0] restartPick;
`endif

  // Channel lookups: first enabled channel for a new scan, and the next
  // enabled channel above the one that is currently selected.
  always_comb begin
    firstPick = pickAbove(mask, 3'd0);
    nextPick  = pickAbove(mask_q, {1'b0, sel_q} + 3'd1);
`ifdef MUX_SCAN_CONT_EN
    restartPick = firstPick;
`endif
  end

  // Next-state logic. IDLE accepts a start, DWELL holds the select for the
  // settle time, SAMPLE captures the mux output and advances to the next
  // channel, and FINISH reports completion.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    mask_d   = mask_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d   = mask;
          sample_d = 4'b0000;
          if (firstPick[2]) begin
            sel_d   = firstPick[1:0];
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = ST_DWELL;
          end else begin
            valid_d = 1'b1;
            state_d = ST_FINISH;
          end
        end
      end
      ST_DWELL: begin
        if (cnt_q == DwellLast) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        sample_d[sel_q] = mux_out;
        if (nextPick[2]) begin
          sel_d   = nextPick[1:0];
          cnt_d   = '0;
          state_d = ST_DWELL;
        end else begin
          valid_d = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
`ifdef MUX_SCAN_CONT_EN
        if (start) begin
          mask_d   = mask;
          sample_d = sample_q & mask;
          if (restartPick[2]) begin
            sel_d   = restartPick[1:0];
            cnt_d   = '0;
            state_d = ST_DWELL;
          end else begin
            sample_d = 4'b0000;
            state_d  = ST_FINISH;
          end
        end else begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sel_q    <= 2'b00;
      mask_q   <= 4'b0000;
      sample_q <= 4'b0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      mask_q   <= mask_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  // Outputs are decoded directly from the registered state.
  always_comb begin
    s1           = sel_q[1];
    s0           = sel_q[0];
    busy         = (state_q == ST_DWELL) || (state_q == ST_SAMPLE);
    done         = (state_q == ST_FINISH);
    sample       = sample_q;
    sample_valid = valid_q;
  end

endmodule

// File: doc/mux_sel_scanner.md
Name: mux_sel_scanner

Overview:
- Sequencer directly upstream of the 4-to-1 gate-level multiplexer. Drives its select lines s1/s0 through the enabled input channels.
- Holds each select for a programmable dwell so the mux output settles, then samples the mux output back into a 4-bit snapshot word.
- Start/done handshake to the controlling logic; optional free-running continuous scan.

Parameters:
- DWELL, 2, clock cycles each select value is held before sampling; legal range 1..(2^CNT_W - 1)
- CNT_W, 4, width of the dwell counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a scan; sampled only in IDLE
- mask  input  4  channel enable, bit k = channel k (i0..i3); latched on accepted start
- mux_out  input  1  output of the downstream 4-to-1 mux
- s1  output  1  select MSB to the mux
- s0  output  1  select LSB to the mux
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse at scan completion
- sample  output  4  captured mux_out per channel; bit k = value read with {s1,s0}=k
- sample_valid  output  1  sample holds a complete scan result

Behaviour:
- Reset (synchronous, active-high) applies to all outputs and state, including mid-scan:
  - s1=0, s0=0, busy=0, done=0, sample=0, sample_valid=0.
  - FSM=IDLE, dwell counter=0, latched mask=0.
  - A scan in progress is abandoned with no done pulse.
- FSM states: IDLE, DWELL, SAMPLE, FINISH.
- IDLE:
  - Select lines hold their last value.
  - start=1 with mask!=0: latch mask, clear sample, drop sample_valid, load the lowest enabled channel onto {s1,s0}, set busy, go to DWELL with counter=0.
  - start=1 with mask==0: go to FINISH; sample=0; no select change.
- DWELL:
  - {s1,s0} held stable; counter increments each cycle.
  - When counter reaches DWELL-1, go to SAMPLE on the next edge.
- SAMPLE:
  - Lasts 1 cycle; mux_out is registered into sample[{s1,s0}] at the end of this cycle.
  - If a higher-indexed enabled channel exists, load it onto {s1,s0}, counter=0, return to DWELL.
  - Otherwise go to FINISH.
- FINISH:
  - Lasts 1 cycle; done=1, busy=0, sample_valid=1; then go to IDLE.
- Dwell and sample timing:
  - Each enabled channel occupies DWELL cycles in DWELL plus 1 cycle in SAMPLE, so select is stable for DWELL+1 cycles before the capture edge.
  - Masked channels are skipped with zero cycles and read back as 0.
- Latency: with start accepted at cycle 0 and N enabled channels, done is high in cycle 1 + N*(DWELL+1). For mask=0, done is high in cycle 1.
- Scan order is always ascending channel index (0 to 3); there is no wrap within a scan.
- start while busy or in FINISH is ignored (no queuing).
- Changes on mask during a scan have no effect.
- sample and sample_valid hold after done until the next accepted start or reset.
- Unlatched interface: mux_out is treated as synchronous to clk; no synchronizer is included.

Optional Feature:
- Macro: MUX_SCAN_CONT_EN.
- Defined:
  - FINISH returns directly to the first enabled channel's DWELL instead of IDLE, without needing start, as long as start is held high.
  - done pulses once per completed scan.
  - sample updates per channel as captured; sample_valid stays high after the first complete scan.
  - Dropping start lets the current scan finish, then returns to IDLE.
  - mask is relatched at each restart.
- Not defined: a single scan per start, exactly as described above.

Test Plan:
- Reset, then mux_out driven by a model of the 4-to-1 mux with i0..i3=1,0,1,1; start pulse, mask=1111, DWELL=2 -> {s1,s0} steps 00,01,10,11, each held 3 cycles; done in cycle 13; sample=1101 (bit3..bit0); sample_valid=1.
- mask=0101, inputs i0..i3=1,1,1,1 -> only selects 00 and 10 are visited; done in cycle 7; sample=0101.
- start with mask=0000 -> done in cycle 1; busy never high; sample=0000; selects unchanged.
- Reset asserted during the 3rd channel of a 1111 scan -> next cycle all outputs are 0 and FSM is IDLE; no done pulse; a new start then completes normally.
- start re-pulsed and mask changed mid-scan -> ignored; the original mask is scanned; exactly one done pulse.
- MUX_SCAN_CONT_EN defined, start held high, mask=0011, DWELL=1 -> done pulses every 5 cycles (first in cycle 5); inputs toggled between scans are reflected in sample.
